// File: rtl/memory_port_arbiter.sv
// Two-requester arbiter sharing one sram-like memory port between instruction and data RAM interfaces.
// Address phase is a combinational mux; in-order responses are routed back through an outstanding-ID FIFO.
module memory_port_arbiter #(
  parameter int unsigned OUTSTANDING  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        inst_request,
  input  logic        inst_write,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_address,
  input  logic [31:0] inst_write_data,
  input  logic [3:0]  inst_write_strobe,
  output logic        inst_address_ready,
  output logic        inst_data_ready,
  output logic [31:0] inst_read_data,

  input  logic        data_request,
  input  logic        data_write,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_address,
  input  logic [31:0] data_write_data,
  input  logic [3:0]  data_write_strobe,
  output logic        data_address_ready,
  output logic        data_data_ready,
  output logic [31:0] data_read_data,

  output logic        mem_request,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_strobe,
  input  logic        mem_address_ready,
  input  logic        mem_data_ready,
  input  logic [31:0] mem_read_data,

  output logic        protocol_error
);

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  owner_e             owner_q;
  owner_e             owner;
  logic               lock_q;
  owner_e             id_mem [OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [STV_W-1:0]   starve_cnt;

  logic               owner_request;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               resp_valid;
  owner_e             head;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // While locked the owner is frozen so the stalled address stays stable at the slave.
  always_comb begin
    owner = OWNER_DATA;
    if (lock_q) begin
      owner = owner_q;
    end else if (inst_request && (!data_request || starve_cnt == STV_MAX)) begin
      owner = OWNER_INST;
    end
  end

  always_comb begin
    owner_request    = data_request;
    mem_write        = data_write;
    mem_size         = data_size;
    mem_address      = data_address;
    mem_write_data   = data_write_data;
    mem_write_strobe = data_write_strobe;
    if (owner == OWNER_INST) begin
      owner_request    = inst_request;
      mem_write        = inst_write;
      mem_size         = inst_size;
      mem_address      = inst_address;
      mem_write_data   = inst_write_data;
      mem_write_strobe = inst_write_strobe;
    end
  end

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign head       = id_mem[rd_ptr];

  // A full FIFO blocks the request even when a pop lands in the same cycle.
  assign mem_request = !reset && owner_request && !fifo_full;
  assign accept      = mem_request && mem_address_ready;

  assign inst_address_ready = accept && (owner == OWNER_INST);
  assign data_address_ready = accept && (owner == OWNER_DATA);

  assign resp_valid      = !reset && mem_data_ready && !fifo_empty;
  assign inst_data_ready = resp_valid && (head == OWNER_INST);
  assign data_data_ready = resp_valid && (head == OWNER_DATA);
  assign inst_read_data  = mem_read_data;
  assign data_read_data  = mem_read_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q        <= OWNER_DATA;
      lock_q         <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      starve_cnt     <= '0;
      protocol_error <= 1'b0;
      for (int unsigned i = 0; i < OUTSTANDING; i++) begin
        id_mem[i] <= OWNER_DATA;
      end
    end else begin
      owner_q <= owner;

      if (accept) begin
        lock_q <= 1'b0;
      end else if (mem_request) begin
        lock_q <= 1'b1;
      end

      if (accept) begin
        id_mem[wr_ptr] <= owner;
        wr_ptr         <= ptr_next(wr_ptr);
      end
      if (resp_valid) begin
        rd_ptr <= ptr_next(rd_ptr);
      end

      case ({accept, resp_valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (mem_data_ready && fifo_empty) begin
        protocol_error <= 1'b1;
      end

      if (!inst_request) begin
        starve_cnt <= '0;
      end else if (accept && owner == OWNER_INST) begin
        starve_cnt <= '0;
      end else if (accept && starve_cnt != STV_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: a per-cycle vector table plus hand sequences
// for starvation, address lock and reset during outstanding traffic.
module tb_memory_port_arbiter;

  localparam logic [31:0] IA = 32'h1000_0040;
  localparam logic [31:0] DA = 32'h2000_0080;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_request, data_request;
  logic        inst_address_ready, data_address_ready;
  logic        inst_data_ready, data_data_ready;
  logic [31:0] inst_read_data, data_read_data;
  logic        mem_request, mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_address, mem_write_data;
  logic [3:0]  mem_write_strobe;
  logic        mem_address_ready, mem_data_ready;
  logic [31:0] mem_read_data;
  logic        protocol_error;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  memory_port_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .inst_request       (inst_request),
    .inst_write         (1'b0),
    .inst_size          (2'd2),
    .inst_address       (IA),
    .inst_write_data    (32'h0),
    .inst_write_strobe  (4'h0),
    .inst_address_ready (inst_address_ready),
    .inst_data_ready    (inst_data_ready),
    .inst_read_data     (inst_read_data),
    .data_request       (data_request),
    .data_write         (1'b1),
    .data_size          (2'd2),
    .data_address       (DA),
    .data_write_data    (32'hDEAD_BEEF),
    .data_write_strobe  (4'hF),
    .data_address_ready (data_address_ready),
    .data_data_ready    (data_data_ready),
    .data_read_data     (data_read_data),
    .mem_request        (mem_request),
    .mem_write          (mem_write),
    .mem_size           (mem_size),
    .mem_address        (mem_address),
    .mem_write_data     (mem_write_data),
    .mem_write_strobe   (mem_write_strobe),
    .mem_address_ready  (mem_address_ready),
    .mem_data_ready     (mem_data_ready),
    .mem_read_data      (mem_read_data),
    .protocol_error     (protocol_error)
  );

  typedef struct {
    logic        ir, dr, ardy, drdy;
    logic [31:0] rdata;
    logic        mreq;
    logic [31:0] maddr;
    logic        iar, dar, idr, ddr, perr;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic ir, dr, ardy, drdy, input logic [31:0] rdata,
                              input logic mreq, input logic [31:0] maddr,
                              input logic iar, dar, idr, ddr, perr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.ardy = ardy; v.drdy = drdy; v.rdata = rdata;
    v.mreq = mreq; v.maddr = maddr; v.iar = iar; v.dar = dar;
    v.idr = idr; v.ddr = ddr; v.perr = perr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, dr, ardy, drdy, input logic [31:0] rdata);
    inst_request      = ir;
    data_request      = dr;
    mem_address_ready = ardy;
    mem_data_ready    = drdy;
    mem_read_data     = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("reset_perr", protocol_error, 1'b0);
    chk("reset_mreq", mem_request, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic own_inst [7];

    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0);

    // Outputs gated while reset is held, even with every request active.
    @(negedge clock);
    chk("rst_mreq", mem_request, 1'b0);
    chk("rst_iar", inst_address_ready, 1'b0);
    chk("rst_dar", data_address_ready, 1'b0);
    chk("rst_idr", inst_data_ready, 1'b0);
    chk("rst_ddr", data_data_ready, 1'b0);
    chk("rst_perr", protocol_error, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    reset = 1'b0;

    //            ir  dr  ardy drdy rdata          mreq maddr iar dar idr ddr perr
    tbl[0]  = mk(0,  1,  1,   0,   32'h0,         1,   DA,   0,  1,  0,  0,  0);
    tbl[1]  = mk(0,  0,  1,   1,   32'h1111_1111, 0,   DA,   0,  0,  0,  1,  0);
    tbl[2]  = mk(1,  0,  1,   0,   32'h0,         1,   IA,   1,  0,  0,  0,  0);
    tbl[3]  = mk(0,  1,  1,   0,   32'h0,         1,   DA,   0,  1,  0,  0,  0);
    tbl[4]  = mk(1,  1,  1,   0,   32'h0,         0,   DA,   0,  0,  0,  0,  0);
    tbl[5]  = mk(0,  0,  0,   1,   32'hAAAA_0001, 0,   DA,   0,  0,  1,  0,  0);
    tbl[6]  = mk(0,  0,  0,   1,   32'hBBBB_0002, 0,   DA,   0,  0,  0,  1,  0);
    tbl[7]  = mk(1,  0,  1,   0,   32'h0,         1,   IA,   1,  0,  0,  0,  0);
    tbl[8]  = mk(1,  0,  1,   0,   32'h0,         1,   IA,   1,  0,  0,  0,  0);
    tbl[9]  = mk(1,  0,  1,   1,   32'hCCCC_0003, 0,   IA,   0,  0,  1,  0,  0);
    tbl[10] = mk(1,  0,  1,   0,   32'h0,         1,   IA,   1,  0,  0,  0,  0);
    tbl[11] = mk(0,  0,  0,   1,   32'hDDDD_0004, 0,   DA,   0,  0,  1,  0,  0);
    tbl[12] = mk(0,  0,  0,   1,   32'hEEEE_0005, 0,   DA,   0,  0,  1,  0,  0);
    tbl[13] = mk(0,  0,  0,   1,   32'hFFFF_0006, 0,   DA,   0,  0,  0,  0,  0);
    tbl[14] = mk(0,  0,  0,   0,   32'h0,         0,   DA,   0,  0,  0,  0,  1);
    tbl[15] = mk(0,  1,  1,   0,   32'h0,         1,   DA,   0,  1,  0,  0,  1);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].ir, tbl[i].dr, tbl[i].ardy, tbl[i].drdy, tbl[i].rdata);
      @(negedge clock);
      chk($sformatf("row%0d_mreq", i), mem_request, tbl[i].mreq);
      chk($sformatf("row%0d_maddr", i), mem_address, tbl[i].maddr);
      chk($sformatf("row%0d_mwrite", i), mem_write, tbl[i].maddr == DA);
      chk($sformatf("row%0d_iar", i), inst_address_ready, tbl[i].iar);
      chk($sformatf("row%0d_dar", i), data_address_ready, tbl[i].dar);
      chk($sformatf("row%0d_idr", i), inst_data_ready, tbl[i].idr);
      chk($sformatf("row%0d_ddr", i), data_data_ready, tbl[i].ddr);
      chk($sformatf("row%0d_perr", i), protocol_error, tbl[i].perr);
      chk($sformatf("row%0d_irdata", i), inst_read_data, tbl[i].rdata);
      chk($sformatf("row%0d_drdata", i), data_read_data, tbl[i].rdata);
      next_cycle();
    end

    // Starvation: four DATA grants, then INST is forced, then DATA wins again.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      own_inst[k] = (k == 4);
      drive(1'b1, 1'b1, 1'b1, k > 0, 32'h5000_0000 + k);
      @(negedge clock);
      chk($sformatf("stv%0d_maddr", k), mem_address, own_inst[k] ? IA : DA);
      chk($sformatf("stv%0d_iar", k), inst_address_ready, own_inst[k]);
      chk($sformatf("stv%0d_dar", k), data_address_ready, !own_inst[k]);
      if (k > 0) begin
        chk($sformatf("stv%0d_idr", k), inst_data_ready, own_inst[k-1]);
        chk($sformatf("stv%0d_ddr", k), data_data_ready, !own_inst[k-1]);
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    @(negedge clock);
    chk("stv_drain_ddr", data_data_ready, 1'b1);
    next_cycle();

    // Address lock: stalled DATA stays on the port while INST asks for it.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    chk("lock0_mreq", mem_request, 1'b1);
    chk("lock0_maddr", mem_address, DA);
    chk("lock0_dar", data_address_ready, 1'b0);
    next_cycle();
    for (int k = 1; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clock);
      chk($sformatf("lock%0d_maddr", k), mem_address, DA);
      chk($sformatf("lock%0d_iar", k), inst_address_ready, 1'b0);
      chk($sformatf("lock%0d_strobe", k), mem_write_strobe, 4'hF);
      next_cycle();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clock);
    chk("lock3_maddr", mem_address, DA);
    chk("lock3_dar", data_address_ready, 1'b1);
    chk("lock3_iar", inst_address_ready, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h6000_0001);
    @(negedge clock);
    chk("lock4_maddr", mem_address, IA);
    chk("lock4_iar", inst_address_ready, 1'b1);
    chk("lock4_ddr", data_data_ready, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h6000_0002);
    @(negedge clock);
    chk("lock5_idr", inst_data_ready, 1'b1);
    chk("lock5_ddr", data_data_ready, 1'b0);
    next_cycle();

    // Reset with an INST transaction outstanding.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clock);
    chk("mid_iar", inst_address_ready, 1'b1);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h7000_0001);
    @(negedge clock);
    chk("mid_idr_pre", inst_data_ready, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_mreq", mem_request, 1'b0);
    chk("mid_rst_iar", inst_address_ready, 1'b0);
    chk("mid_rst_dar", data_address_ready, 1'b0);
    chk("mid_rst_idr", inst_data_ready, 1'b0);
    chk("mid_rst_ddr", data_data_ready, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h7000_0002);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_idr", inst_data_ready, 1'b0);
    chk("post_rst_ddr", data_data_ready, 1'b0);
    chk("post_rst_perr0", protocol_error, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    chk("post_rst_perr1", protocol_error, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
